// File: rtl/fsmc_pkg.sv
// Shared types and constants for the multiplexed FSMC synchronous slave.
package fsmc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADDR    = 2'd1,
      BUS     = 2'd2,
      RD_HOLD = 2'd3
   } fsmc_state_e;

   localparam int FSMC_SYNC_MIN = 2;

   // Sliced to DATA_WIDTH by the user; wide enough for any legal bus.
   localparam logic [63:0] FSMC_TIMEOUT_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/fsmc_sync.sv
// N-stage synchroniser for one active-low FSMC strobe, with registered
// rise/fall pulses that coincide with the synchronised level changing.
module fsmc_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              rise_q;
   logic              fall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {STAGES{RST_VAL}};
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
         fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/fsmc_mux_sync_slave.sv
// Synchronous slave for the address/data-multiplexed FSMC bus, bridging one host
// access to one local-bus transaction. Define FSMC_NWAIT_EN to drive nwait_o.
module fsmc_mux_sync_slave
   import fsmc_pkg::*;
#(
   parameter int ADDR_WIDTH     = 19,
   parameter int DATA_WIDTH     = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   inout  wire  [DATA_WIDTH-1:0]          dat_io,
   input  logic [ADDR_WIDTH-DATA_WIDTH-1:0] adr_hi_i,
   input  logic                           ne_i,
   input  logic                           noe_i,
   input  logic                           nwe_i,
   input  logic                           nadv_i,
   input  logic [DATA_WIDTH/8-1:0]        nbl_i,
   output logic                           nwait_o,
   output logic                           stb_o,
   output logic                           we_o,
   output logic [ADDR_WIDTH-1:0]          adr_o,
   output logic [DATA_WIDTH/8-1:0]        sel_o,
   output logic [DATA_WIDTH-1:0]          dat_o,
   input  logic [DATA_WIDTH-1:0]          dat_i,
   input  logic                           ack_i,
   output logic                           err_o
);

   localparam int SYNC_N = (SYNC_STAGES < FSMC_SYNC_MIN) ? FSMC_SYNC_MIN : SYNC_STAGES;
   localparam int AH_W   = ADDR_WIDTH - DATA_WIDTH;
   localparam int NB_W   = DATA_WIDTH / 8;
   localparam int DL_W   = AH_W + NB_W + DATA_WIDTH;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

`ifdef FSMC_NWAIT_EN
   localparam logic NWAIT_EN = 1'b1;
`else
   localparam logic NWAIT_EN = 1'b0;
`endif

   logic ne_s, ne_rise_s, ne_fall_s;
   logic noe_s, noe_rise_s, noe_fall_s;
   logic nwe_s, nwe_rise_s, nwe_fall_s;
   logic nadv_s, nadv_rise_s, nadv_fall_s;
   logic unused_s;

   fsmc_sync #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_sync_ne (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(ne_i),
      .q_o(ne_s), .rise_o(ne_rise_s), .fall_o(ne_fall_s));
   fsmc_sync #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_sync_noe (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(noe_i),
      .q_o(noe_s), .rise_o(noe_rise_s), .fall_o(noe_fall_s));
   fsmc_sync #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_sync_nwe (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(nwe_i),
      .q_o(nwe_s), .rise_o(nwe_rise_s), .fall_o(nwe_fall_s));
   fsmc_sync #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_sync_nadv (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(nadv_i),
      .q_o(nadv_s), .rise_o(nadv_rise_s), .fall_o(nadv_fall_s));

   assign unused_s = ne_fall_s ^ noe_rise_s ^ nwe_fall_s ^ nadv_fall_s;

   // Data-side delay line: its last stage holds the pins as they were when
   // the matching control edge first reached the synchronisers.
   logic [SYNC_N-1:0][DL_W-1:0] dl_q;
   logic [DATA_WIDTH-1:0]       ad_cap_s;
   logic [NB_W-1:0]             nbl_cap_s;
   logic [AH_W-1:0]             ahi_cap_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dl_q <= '0;
      end else begin
         dl_q <= {dl_q[SYNC_N-2:0], {adr_hi_i, nbl_i, dat_io}};
      end
   end

   assign ad_cap_s  = dl_q[SYNC_N-1][DATA_WIDTH-1:0];
   assign nbl_cap_s = dl_q[SYNC_N-1][DATA_WIDTH +: NB_W];
   assign ahi_cap_s = dl_q[SYNC_N-1][DATA_WIDTH+NB_W +: AH_W];

   fsmc_state_e           state_q;
   logic                  stb_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [NB_W-1:0]       sel_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rd_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  abort_q;
   logic                  nwait_q;
   logic                  timeout_s;
   logic                  drive_s;

   assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Transaction sequencer: host strobes in, one local-bus access out.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         err_q   <= 1'b0;
         rd_q    <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
         nwait_q <= 1'b1;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (nadv_rise_s && !ne_s) begin
                  adr_q   <= {ahi_cap_s, ad_cap_s};
                  state_q <= ADDR;
               end
            end
            ADDR: begin
               if (!noe_s && !nwe_s) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (noe_fall_s) begin
                  we_q    <= 1'b0;
                  sel_q   <= ~nbl_cap_s;
                  stb_q   <= 1'b1;
                  cnt_q   <= '0;
                  abort_q <= 1'b0;
                  nwait_q <= ~NWAIT_EN;
                  state_q <= BUS;
               end else if (nwe_rise_s) begin
                  we_q    <= 1'b1;
                  dat_q   <= ad_cap_s;
                  sel_q   <= ~nbl_cap_s;
                  stb_q   <= 1'b1;
                  cnt_q   <= '0;
                  abort_q <= 1'b0;
                  nwait_q <= ~NWAIT_EN;
                  state_q <= BUS;
               end else if (ne_rise_s) begin
                  state_q <= IDLE;
               end
            end
            BUS: begin
               if (ne_rise_s) begin
                  abort_q <= 1'b1;
               end
               // An ack in the timeout cycle wins: the access completed in time.
               if (ack_i || timeout_s) begin
                  stb_q <= 1'b0;
                  err_q <= ~ack_i;
                  if (!we_q && !abort_q && !ne_s) begin
                     rd_q    <= ack_i ? dat_i : FSMC_TIMEOUT_FILL[DATA_WIDTH-1:0];
                     state_q <= RD_HOLD;
                  end else begin
                     nwait_q <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RD_HOLD: begin
               nwait_q <= 1'b1;
               if (noe_s || ne_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Turn-off follows the raw pins so the host never fights a late driver.
   assign drive_s = rst_ni & ~ne_i & ~noe_i & nadv_s;
   assign dat_io  = drive_s ? rd_q : {DATA_WIDTH{1'bz}};

   assign nwait_o = nwait_q;
   assign stb_o   = stb_q;
   assign we_o    = we_q;
   assign adr_o   = adr_q;
   assign sel_o   = sel_q;
   assign dat_o   = dat_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_fsmc_mux_sync_slave.sv
// Randomised bench for fsmc_mux_sync_slave: a host bus-functional model, a
// local-bus responder and a transaction-level expectation model.
module tb_fsmc_mux_sync_slave;

   localparam int TO = 8;

`ifdef FSMC_NWAIT_EN
   localparam logic NW_BUSY = 1'b0;
`else
   localparam logic NW_BUSY = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   wire  [15:0] ad;
   logic        host_oe = 1'b0;
   logic [15:0] host_ad = 16'h0;
   logic [2:0]  adr_hi = 3'h0;
   logic        ne = 1'b1, noe = 1'b1, nwe = 1'b1, nadv = 1'b1;
   logic [1:0]  nbl = 2'b11;
   logic        nwait, stb, we, err;
   logic [18:0] adr;
   logic [1:0]  sel;
   logic [15:0] dat_out;
   logic [15:0] dat_in = 16'h0;
   logic        ack = 1'b0;

   assign ad = host_oe ? host_ad : 16'hzzzz;

   always #5 clk = ~clk;

   fsmc_mux_sync_slave #(
      .ADDR_WIDTH(19), .DATA_WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .dat_io(ad), .adr_hi_i(adr_hi),
      .ne_i(ne), .noe_i(noe), .nwe_i(nwe), .nadv_i(nadv), .nbl_i(nbl),
      .nwait_o(nwait), .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel),
      .dat_o(dat_out), .dat_i(dat_in), .ack_i(ack), .err_o(err)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // Responder configuration written by the host tasks.
   int          lat_cfg = 0;
   logic        noack_cfg = 1'b0;
   logic [15:0] rdata_cfg = 16'h0;

   // Monitor state, written only by the responder process.
   int          wait_cnt = 0;
   logic        acked = 1'b0;
   logic        stb_prev = 1'b0;
   int          stb_cyc = 0, stb_rises = 0, err_cyc = 0;
   logic        cap_we = 1'b0;
   logic [18:0] cap_adr = 19'h0;
   logic [1:0]  cap_sel = 2'b00;
   logic [15:0] cap_dat = 16'h0;

   // Local-bus responder and observer; stray acks are thrown in while idle.
   always @(negedge clk) begin
      if (!rst_n) begin
         ack = 1'b0;
         wait_cnt = 0;
         acked = 1'b0;
         stb_prev = 1'b0;
      end else begin
         if (stb) begin
            if (!stb_prev) begin
               stb_rises++;
               cap_we = we; cap_adr = adr; cap_sel = sel; cap_dat = dat_out;
            end
            stb_cyc++;
            check_eq("nwait_busy", nwait, NW_BUSY);
            if (!noack_cfg && !acked && wait_cnt == lat_cfg) begin
               ack = 1'b1;
               dat_in = rdata_cfg;
               acked = 1'b1;
            end else begin
               ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
            acked = 1'b0;
            ack = ($urandom_range(0, 7) == 0);
            dat_in = 16'($urandom);
         end
         if (err) err_cyc++;
         stb_prev = stb;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_stb(input string tag);
      int n = 0;
      while (!stb && n < 40) begin cyc(1); n++; end
      check_eq(tag, stb, 1'b1);
   endtask

   task automatic wait_txn(input int rises0, input string tag);
      int n = 0;
      while (!(stb_rises > rises0 && !stb) && n < 100) begin cyc(1); n++; end
      check_eq(tag, (n < 100), 1'b1);
   endtask

   task automatic addr_phase(input logic [18:0] a);
      ne = 1'b0; nadv = 1'b0; host_oe = 1'b1;
      host_ad = a[15:0]; adr_hi = a[18:16];
      cyc(2);
      nadv = 1'b1;
      cyc(1);
   endtask

   task automatic host_write(input logic [18:0] a, input logic [15:0] d,
                             input logic [1:0] bl, input int lat, input logic noack);
      int r0 = stb_rises;
      int c0 = stb_cyc;
      int e0 = err_cyc;
      logic [1:0] sel_exp = ~bl;
      lat_cfg = lat; noack_cfg = noack;
      addr_phase(a);
      host_ad = d; nbl = bl; nwe = 1'b0;
      cyc(2);
      nwe = 1'b1;
      cyc(2);
      wait_txn(r0, "wr_done");
      ne = 1'b1; host_oe = 1'b0; nbl = 2'b11;
      cyc(4);
      check_eq("wr_stb_count", stb_rises - r0, 1);
      check_eq("wr_we", cap_we, 1'b1);
      check_eq("wr_adr", cap_adr, a);
      check_eq("wr_dat", cap_dat, d);
      check_eq("wr_sel", cap_sel, sel_exp);
      check_eq("wr_stb_len", stb_cyc - c0, noack ? TO : lat + 1);
      check_eq("wr_err", err_cyc - e0, noack ? 1 : 0);
   endtask

   task automatic host_read(input logic [18:0] a, input logic [1:0] bl, input int lat,
                            input logic [15:0] rd, input logic noack, input logic abort);
      int r0 = stb_rises;
      int c0 = stb_cyc;
      int e0 = err_cyc;
      logic [1:0] sel_exp = ~bl;
      logic [15:0] rd_exp = noack ? 16'hFFFF : rd;
      lat_cfg = lat; noack_cfg = noack; rdata_cfg = rd;
      addr_phase(a);
      host_oe = 1'b0; noe = 1'b0; nbl = bl;
      if (abort) begin
         wait_stb("rd_abort_stb");
         ne = 1'b1; noe = 1'b1;
         wait_txn(r0, "rd_abort_done");
      end else begin
         wait_txn(r0, "rd_done");
         cyc(2);
         check_eq("rd_pins", ad, rd_exp);
      end
      noe = 1'b1; ne = 1'b1; nbl = 2'b11;
      cyc(4);
      check_eq("rd_stb_count", stb_rises - r0, 1);
      check_eq("rd_we", cap_we, 1'b0);
      check_eq("rd_adr", cap_adr, a);
      check_eq("rd_sel", cap_sel, sel_exp);
      check_eq("rd_stb_len", stb_cyc - c0, noack ? TO : lat + 1);
      check_eq("rd_err", err_cyc - e0, noack ? 1 : 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int r0;
      int e0;
      cyc(3);
      check_eq("rst_stb", stb, 1'b0);
      check_eq("rst_we", we, 1'b0);
      check_eq("rst_adr", adr, 19'h0);
      check_eq("rst_sel", sel, 2'b00);
      check_eq("rst_dat", dat_out, 16'h0);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_nwait", nwait, 1'b1);
      rst_n = 1'b1;
      cyc(3);

      host_write(19'h4_1234, 16'hBEEF, 2'b00, 3, 1'b0);
      host_read(19'h0_0010, 2'b00, TO - 1, 16'h5A5A, 1'b0, 1'b0);
      host_read(19'h1_2345, 2'b00, 0, 16'h0000, 1'b1, 1'b0);
      host_write(19'h0_00A0, 16'h00C3, 2'b10, 0, 1'b0);
      host_write(19'h3_8001, 16'h7E57, 2'b01, 2, 1'b1);

      // Both output and write enable low in the address phase.
      r0 = stb_rises; e0 = err_cyc;
      addr_phase(19'h2_2222);
      host_oe = 1'b0; noe = 1'b0; nwe = 1'b0;
      cyc(6);
      noe = 1'b1; nwe = 1'b1; ne = 1'b1;
      cyc(4);
      check_eq("proto_no_stb", stb_rises - r0, 0);
      check_eq("proto_err", err_cyc - e0, 1);

      host_read(19'h5_0505, 2'b00, 6, 16'h9999, 1'b0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         int kind = $urandom_range(0, 3);
         logic [18:0] a = 19'($urandom);
         logic [15:0] d = 16'($urandom);
         logic [1:0]  bl = 2'($urandom);
         int lat = $urandom_range(0, TO - 1);
         case (kind)
            0: host_write(a, d, bl, lat, 1'b0);
            1: host_read(a, bl, lat, d, 1'b0, 1'b0);
            2: host_read(a, bl, lat, d, 1'b1, 1'b0);
            default: host_write(a, d, bl, lat, 1'b1);
         endcase
      end

      // Reset pulled while a write sits in the bus phase.
      noack_cfg = 1'b1;
      addr_phase(19'h2_0F0F);
      host_ad = 16'hA5C3; nbl = 2'b00; nwe = 1'b0;
      cyc(2);
      nwe = 1'b1;
      cyc(1);
      wait_stb("mid_rst_stb");
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_stb_low", stb, 1'b0);
      check_eq("mid_rst_we", we, 1'b0);
      check_eq("mid_rst_adr", adr, 19'h0);
      check_eq("mid_rst_sel", sel, 2'b00);
      check_eq("mid_rst_dat", dat_out, 16'h0);
      check_eq("mid_rst_err", err, 1'b0);
      check_eq("mid_rst_nwait", nwait, 1'b1);
      ne = 1'b1; host_oe = 1'b0; nbl = 2'b11;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      host_write(19'h7_FFFF, 16'h1357, 2'b00, 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
